prirv32_idu: RTL and testbench

Instruction decode unit for the priRV32 core; the producer side of the EXU operand interface. It accepts one RV32I instruction word per handshake from the fetch unit and decodes it. It reads both source operands from the external register file, with a writeback bypass, and presents a registered decoded bundle (`imm_decoded`, `rs1_decoded`, `rs2_decoded`, `pc_latched`, `rd_reg`, `rs1_reg`, `rs2_reg`, `instrset_latched`) to the EXU under a valid/ready handshake. It is a single pipeline stage with stall and flush support.

---
 rtl/prirv32_pkg.sv | 64 ++++++
 rtl/prirv32_idu_if.sv | 29 ++
 rtl/prirv32_imm_gen.sv | 22 ++
 rtl/prirv32_idu.sv | 212 +++++++++++++++++++++
 tb/tb_prirv32_idu.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prirv32_pkg.sv
// priRV32 shared decode package: instruction IDs, opcodes, immediate
// formats, the ID->EX bundle and the operand bypass helper.
package prirv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [5:0] {
        ID_ILLEGAL = 6'd0,
        ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
        ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
        ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
        ID_SB, ID_SH, ID_SW,
        ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI,
        ID_SLLI, ID_SRLI, ID_SRAI,
        ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU,
        ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND,
        ID_FENCE, ID_ECALL, ID_EBREAK,
        ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
        ID_DIV, ID_DIVU, ID_REM, ID_REMU
    } instr_id_e;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        instr_id_e   id;
    } id_ex_t;

    // x0 reads as zero and wins over a writeback to x0
    function automatic logic [31:0] op_sel(
        input logic [4:0]  idx,
        input logic        wb_en,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data,
        input logic [31:0] rf_data
    );
        if (idx == 5'd0) return '0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/prirv32_idu_if.sv
// IDU -> EXU decoded-operand interface: valid/ready handshake plus bundle.
// master = IDU (drives bundle, reads exu_ready_i), slave = EXU.
interface prirv32_idu_if #(
    parameter int XLEN = 32,
    parameter int ID_W = 6
);
    logic            dec_valid_o;
    logic            exu_ready_i;
    logic [XLEN-1:0] imm_decoded;
    logic [XLEN-1:0] rs1_decoded;
    logic [XLEN-1:0] rs2_decoded;
    logic [XLEN-1:0] pc_latched;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic [4:0]      rd_reg;
    logic [ID_W-1:0] instrset_latched;

    modport master (
        output dec_valid_o, imm_decoded, rs1_decoded, rs2_decoded,
        output pc_latched, rs1_reg, rs2_reg, rd_reg, instrset_latched,
        input  exu_ready_i
    );

    modport slave (
        input  dec_valid_o, imm_decoded, rs1_decoded, rs2_decoded,
        input  pc_latched, rs1_reg, rs2_reg, rd_reg, instrset_latched,
        output exu_ready_i
    );
endinterface

// File: rtl/prirv32_imm_gen.sv
// Immediate generator: instr[31:7] + format -> sign-extended 32-bit imm.
// Ports: instr (in 25), fmt (in imm_fmt_e), imm (out 32). Combinational.
module prirv32_imm_gen
    import prirv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    always_comb begin
        unique case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/prirv32_idu.sv
// priRV32 decode stage: RV32I decode, operand read with WB bypass, one
// registered bundle to the EXU. Ports: clk_i, rst_n, IFU (instr_i, pc_i,
// instr_valid_i, idu_ready_o), regfile read/WB bypass, flush_i, exu
// (prirv32_idu_if.master). Macro PRIRV32_RV32M_EN enables M-extension IDs.
module prirv32_idu
    import prirv32_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            instr_valid_i,
    output logic            idu_ready_o,
    output logic [4:0]      rf_rs1_addr_o,
    output logic [4:0]      rf_rs2_addr_o,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic [XLEN-1:0] rf_rs2_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    prirv32_idu_if.master   exu
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    instr_id_e  id;
    imm_fmt_e   fmt;
    logic [31:0] imm;
    logic       has_rs2;
    logic       has_rd;
    logic       accept;
    id_ex_t     d;
    id_ex_t     q;
    logic       q_valid;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign rf_rs1_addr_o = instr_i[19:15];
    assign rf_rs2_addr_o = instr_i[24:20];

    // Format follows the major opcode even when funct bits are illegal;
    // unknown opcodes fall back to R so the immediate reads as zero.
    always_comb begin
        id  = ID_ILLEGAL;
        fmt = FMT_R;
        case (opc)
            OPC_LUI:   begin fmt = FMT_U; id = ID_LUI;   end
            OPC_AUIPC: begin fmt = FMT_U; id = ID_AUIPC; end
            OPC_JAL:   begin fmt = FMT_J; id = ID_JAL;   end
            OPC_JALR: begin
                fmt = FMT_I;
                if (f3 == 3'd0) id = ID_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'd0:    id = ID_BEQ;
                    3'd1:    id = ID_BNE;
                    3'd4:    id = ID_BLT;
                    3'd5:    id = ID_BGE;
                    3'd6:    id = ID_BLTU;
                    3'd7:    id = ID_BGEU;
                    default: id = ID_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'd0:    id = ID_LB;
                    3'd1:    id = ID_LH;
                    3'd2:    id = ID_LW;
                    3'd4:    id = ID_LBU;
                    3'd5:    id = ID_LHU;
                    default: id = ID_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'd0:    id = ID_SB;
                    3'd1:    id = ID_SH;
                    3'd2:    id = ID_SW;
                    default: id = ID_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    3'd0: id = ID_ADDI;
                    3'd2: id = ID_SLTI;
                    3'd3: id = ID_SLTIU;
                    3'd4: id = ID_XORI;
                    3'd6: id = ID_ORI;
                    3'd7: id = ID_ANDI;
                    3'd1: if (f7 == F7_BASE) id = ID_SLLI;
                    3'd5: begin
                        if (f7 == F7_BASE) id = ID_SRLI;
                        else if (f7 == F7_ALT) id = ID_SRAI;
                    end
                    default: id = ID_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'd0:    id = ID_ADD;
                        3'd1:    id = ID_SLL;
                        3'd2:    id = ID_SLT;
                        3'd3:    id = ID_SLTU;
                        3'd4:    id = ID_XOR;
                        3'd5:    id = ID_SRL;
                        3'd6:    id = ID_OR;
                        default: id = ID_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'd0) id = ID_SUB;
                    else if (f3 == 3'd5) id = ID_SRA;
                end
`ifdef PRIRV32_RV32M_EN
                else if (f7 == F7_MUL) begin
                    case (f3)
                        3'd0:    id = ID_MUL;
                        3'd1:    id = ID_MULH;
                        3'd2:    id = ID_MULHSU;
                        3'd3:    id = ID_MULHU;
                        3'd4:    id = ID_DIV;
                        3'd5:    id = ID_DIVU;
                        3'd6:    id = ID_REM;
                        default: id = ID_REMU;
                    endcase
                end
`else
                else begin
                    id = ID_ILLEGAL;
                end
`endif
            end
            OPC_FENCE: begin
                fmt = FMT_I;
                if (f3 == 3'd0) id = ID_FENCE;
            end
            OPC_SYSTEM: begin
                fmt = FMT_I;
                if (instr_i == 32'h0000_0073) id = ID_ECALL;
                else if (instr_i == 32'h0010_0073) id = ID_EBREAK;
            end
            default: begin
                id  = ID_ILLEGAL;
                fmt = FMT_R;
            end
        endcase
    end

    prirv32_imm_gen u_imm_gen (
        .instr (instr_i[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    assign has_rs2 = (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
    assign has_rd  = !((fmt == FMT_S) || (fmt == FMT_B));

    always_comb begin
        d         = '0;
        d.imm     = imm;
        d.rs1     = instr_i[19:15];
        d.rs2     = has_rs2 ? instr_i[24:20] : 5'd0;
        d.rd      = has_rd ? instr_i[11:7] : 5'd0;
        d.pc      = pc_i;
        d.id      = id;
        d.rs1_val = op_sel(d.rs1, wb_en_i, wb_addr_i, wb_data_i,
                           rf_rs1_data_i);
        d.rs2_val = op_sel(d.rs2, wb_en_i, wb_addr_i, wb_data_i,
                           rf_rs2_data_i);
    end

    // flush makes the IFU see the incoming word as taken, then drops it
    assign idu_ready_o = !q_valid || exu.exu_ready_i || flush_i;
    assign accept      = instr_valid_i && idu_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (flush_i) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q       <= d;
        end else if (exu.exu_ready_i) begin
            q_valid <= 1'b0;
        end
    end

    assign exu.dec_valid_o      = q_valid;
    assign exu.imm_decoded      = q.imm;
    assign exu.rs1_decoded      = q.rs1_val;
    assign exu.rs2_decoded      = q.rs2_val;
    assign exu.pc_latched       = q.pc;
    assign exu.rs1_reg          = q.rs1;
    assign exu.rs2_reg          = q.rs2;
    assign exu.rd_reg           = q.rd;
    assign exu.instrset_latched = ID_W'(q.id);

endmodule

// File: tb/tb_prirv32_idu.sv
// Randomized self-checking bench for prirv32_idu against a behavioural
// model of decode, operand bypass and the valid/ready stage.
module tb_prirv32_idu;
    import prirv32_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i, pc_i;
    logic        instr_valid_i;
    logic        idu_ready_o;
    logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o;
    logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        flush_i;

    always #5 clk_i = ~clk_i;

    prirv32_idu_if #(.XLEN(32), .ID_W(6)) exu ();

    prirv32_idu #(.XLEN(32), .ID_W(6)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .instr_valid_i (instr_valid_i),
        .idu_ready_o   (idu_ready_o),
        .rf_rs1_addr_o (rf_rs1_addr_o),
        .rf_rs2_addr_o (rf_rs2_addr_o),
        .rf_rs1_data_i (rf_rs1_data_i),
        .rf_rs2_data_i (rf_rs2_data_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .exu           (exu)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          kind;
        logic [31:0] word;
        instr_id_e   id;
        byte         fmt;
    } op_t;

    op_t         ops[$];
    logic [31:0] rf[32];
    int          n_checks;
    int          n_errors;

    bit          m_valid;
    logic [31:0] m_imm, m_rs1v, m_rs2v, m_pc;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    instr_id_e   m_id;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void add(input logic [6:0] opc, input int kind,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] word, input instr_id_e id,
                                input byte fmt);
        ops.push_back('{opc, f3, f7, kind, word, id, fmt});
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w,
                                            input byte fmt);
        case (fmt)
            "I": return {{20{w[31]}}, w[31:20]};
            "S": return {{20{w[31]}}, w[31:25], w[11:7]};
            "B": return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            "U": return {w[31:12], 12'b0};
            "J": return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] i, input bit we,
                                         input logic [4:0] wa,
                                         input logic [31:0] wd);
        if (i == 0) return 32'd0;
        if (we && wa == i) return wd;
        return rf[i];
    endfunction

    function automatic logic [31:0] mk(input op_t o);
        logic [31:0] w;
        w = $urandom;
        if (o.kind == 3) return o.word;
        w[6:0] = o.opc;
        if (o.kind >= 1) w[14:12] = o.f3;
        if (o.kind == 2) w[31:25] = o.f7;
        return w;
    endfunction

    task automatic build_ops();
        instr_id_e mids[8];
`ifdef PRIRV32_RV32M_EN
        mids = '{ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
                 ID_DIV, ID_DIVU, ID_REM, ID_REMU};
`else
        foreach (mids[k]) mids[k] = ID_ILLEGAL;
`endif
        add(7'b0110111, 0, 0, 0, 0, ID_LUI, "U");
        add(7'b0010111, 0, 0, 0, 0, ID_AUIPC, "U");
        add(7'b1101111, 0, 0, 0, 0, ID_JAL, "J");
        add(7'b1100111, 1, 0, 0, 0, ID_JALR, "I");
        add(7'b1100111, 1, 1, 0, 0, ID_ILLEGAL, "I");
        add(7'b1100011, 1, 0, 0, 0, ID_BEQ, "B");
        add(7'b1100011, 1, 1, 0, 0, ID_BNE, "B");
        add(7'b1100011, 1, 4, 0, 0, ID_BLT, "B");
        add(7'b1100011, 1, 5, 0, 0, ID_BGE, "B");
        add(7'b1100011, 1, 6, 0, 0, ID_BLTU, "B");
        add(7'b1100011, 1, 7, 0, 0, ID_BGEU, "B");
        add(7'b0000011, 1, 0, 0, 0, ID_LB, "I");
        add(7'b0000011, 1, 1, 0, 0, ID_LH, "I");
        add(7'b0000011, 1, 2, 0, 0, ID_LW, "I");
        add(7'b0000011, 1, 3, 0, 0, ID_ILLEGAL, "I");
        add(7'b0000011, 1, 4, 0, 0, ID_LBU, "I");
        add(7'b0000011, 1, 5, 0, 0, ID_LHU, "I");
        add(7'b0100011, 1, 0, 0, 0, ID_SB, "S");
        add(7'b0100011, 1, 1, 0, 0, ID_SH, "S");
        add(7'b0100011, 1, 2, 0, 0, ID_SW, "S");
        add(7'b0010011, 1, 0, 0, 0, ID_ADDI, "I");
        add(7'b0010011, 1, 2, 0, 0, ID_SLTI, "I");
        add(7'b0010011, 1, 3, 0, 0, ID_SLTIU, "I");
        add(7'b0010011, 1, 4, 0, 0, ID_XORI, "I");
        add(7'b0010011, 1, 6, 0, 0, ID_ORI, "I");
        add(7'b0010011, 1, 7, 0, 0, ID_ANDI, "I");
        add(7'b0010011, 2, 1, 7'h00, 0, ID_SLLI, "I");
        add(7'b0010011, 2, 5, 7'h00, 0, ID_SRLI, "I");
        add(7'b0010011, 2, 5, 7'h20, 0, ID_SRAI, "I");
        add(7'b0110011, 2, 0, 7'h00, 0, ID_ADD, "R");
        add(7'b0110011, 2, 0, 7'h20, 0, ID_SUB, "R");
        add(7'b0110011, 2, 1, 7'h00, 0, ID_SLL, "R");
        add(7'b0110011, 2, 2, 7'h00, 0, ID_SLT, "R");
        add(7'b0110011, 2, 3, 7'h00, 0, ID_SLTU, "R");
        add(7'b0110011, 2, 4, 7'h00, 0, ID_XOR, "R");
        add(7'b0110011, 2, 5, 7'h00, 0, ID_SRL, "R");
        add(7'b0110011, 2, 5, 7'h20, 0, ID_SRA, "R");
        add(7'b0110011, 2, 6, 7'h00, 0, ID_OR, "R");
        add(7'b0110011, 2, 7, 7'h00, 0, ID_AND, "R");
        add(7'b0110011, 2, 0, 7'h7F, 0, ID_ILLEGAL, "R");
        add(7'b0001111, 1, 0, 0, 0, ID_FENCE, "I");
        add(0, 3, 0, 0, 32'h0000_0073, ID_ECALL, "I");
        add(0, 3, 0, 0, 32'h0010_0073, ID_EBREAK, "I");
        add(7'b1111111, 0, 0, 0, 0, ID_ILLEGAL, "R");
        for (int k = 0; k < 8; k++)
            add(7'b0110011, 2, 3'(k), 7'h01, 0, mids[k], "R");
    endtask

    task automatic check_out();
        chk("dec_valid", {31'b0, exu.dec_valid_o}, {31'b0, m_valid});
        if (m_valid) begin
            chk("imm", exu.imm_decoded, m_imm);
            chk("rs1_val", exu.rs1_decoded, m_rs1v);
            chk("rs2_val", exu.rs2_decoded, m_rs2v);
            chk("pc", exu.pc_latched, m_pc);
            chk("rd", {27'b0, exu.rd_reg}, {27'b0, m_rd});
            chk("rs1", {27'b0, exu.rs1_reg}, {27'b0, m_rs1});
            chk("rs2", {27'b0, exu.rs2_reg}, {27'b0, m_rs2});
            chk("id", {26'b0, exu.instrset_latched}, {26'b0, m_id});
        end
    endtask

    task automatic check_reset();
        chk("rst_valid", {31'b0, exu.dec_valid_o}, 32'd0);
        chk("rst_ready", {31'b0, idu_ready_o}, 32'd1);
        chk("rst_imm", exu.imm_decoded, 32'd0);
        chk("rst_rs1v", exu.rs1_decoded, 32'd0);
        chk("rst_rs2v", exu.rs2_decoded, 32'd0);
        chk("rst_pc", exu.pc_latched, 32'd0);
        chk("rst_regs", {17'b0, exu.rd_reg, exu.rs1_reg, exu.rs2_reg},
            32'd0);
        chk("rst_id", {26'b0, exu.instrset_latched}, 32'd0);
    endtask

    task automatic cyc(input logic [31:0] w, input logic [31:0] pc,
                       input bit v, input bit er, input bit fl,
                       input bit we, input logic [4:0] wa,
                       input logic [31:0] wd,
                       input instr_id_e eid, input byte fmt);
        bit         rdy, acc, has_rs2, has_rd;
        logic [4:0] i1, i2;
        @(negedge clk_i);
        instr_i         = w;
        pc_i            = pc;
        instr_valid_i   = v;
        exu.exu_ready_i = er;
        flush_i         = fl;
        wb_en_i         = we;
        wb_addr_i       = wa;
        wb_data_i       = wd;
        rf_rs1_data_i   = rf[w[19:15]];
        rf_rs2_data_i   = rf[w[24:20]];
        #1;
        rdy = !m_valid || er || fl;
        chk("idu_ready", {31'b0, idu_ready_o}, {31'b0, rdy});
        chk("rf_addrs", {22'b0, rf_rs1_addr_o, rf_rs2_addr_o},
            {22'b0, w[19:15], w[24:20]});
        acc     = v && rdy && !fl;
        has_rs2 = (fmt == "S") || (fmt == "B") || (fmt == "R");
        has_rd  = !((fmt == "S") || (fmt == "B"));
        i1      = w[19:15];
        i2      = has_rs2 ? w[24:20] : 5'd0;
        if (fl) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1;
            m_imm   = exp_imm(w, fmt);
            m_rs1   = i1;
            m_rs2   = i2;
            m_rd    = has_rd ? w[11:7] : 5'd0;
            m_rs1v  = opnd(i1, we, wa, wd);
            m_rs2v  = opnd(i2, we, wa, wd);
            m_pc    = pc;
            m_id    = eid;
        end else if (er) begin
            m_valid = 0;
        end
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    initial begin
        op_t         o;
        logic [31:0] w;
        logic [4:0]  wa;
        instr_id_e   mul_id;
        n_checks = 0;
        n_errors = 0;
        m_valid  = 0;
        rst_n = 1'b0;
        instr_i = 0; pc_i = 0; instr_valid_i = 0; flush_i = 0;
        exu.exu_ready_i = 0;
        wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
        rf_rs1_data_i = 0; rf_rs2_data_i = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        build_ops();
        repeat (3) @(posedge clk_i);
        #1 check_reset();
        @(negedge clk_i) rst_n = 1'b1;

        rf[2] = 32'd7;
        cyc(32'hFFF10093, 32'h100, 1, 1, 0, 0, 0, 0, ID_ADDI, "I");
        chk("addi_valid", {31'b0, exu.dec_valid_o}, 32'd1);
        chk("addi_imm", exu.imm_decoded, 32'hFFFF_FFFF);
        chk("addi_rs1", {27'b0, exu.rs1_reg}, 32'd2);
        chk("addi_rd", {27'b0, exu.rd_reg}, 32'd1);
        chk("addi_rs1v", exu.rs1_decoded, 32'd7);
        chk("addi_pc", exu.pc_latched, 32'h100);
        chk("addi_id", {26'b0, exu.instrset_latched}, {26'b0, ID_ADDI});

        rf[0] = 32'hDEAD;
        cyc(32'hFE000EE3, 32'h104, 1, 1, 0, 0, 0, 0, ID_BEQ, "B");
        chk("beq_imm", exu.imm_decoded, 32'hFFFF_FFFC);
        chk("beq_rd", {27'b0, exu.rd_reg}, 32'd0);
        chk("beq_rs1v", exu.rs1_decoded, 32'd0);
        chk("beq_rs2v", exu.rs2_decoded, 32'd0);

        cyc(32'h123452B7, 32'h108, 1, 1, 0, 0, 0, 0, ID_LUI, "U");
        chk("lui_imm", exu.imm_decoded, 32'h1234_5000);
        chk("lui_rd", {27'b0, exu.rd_reg}, 32'd5);

        for (int k = 0; k < 3; k++) begin
            cyc(32'h00500113, 32'h10C, 1, 0, 0, 0, 0, 0, ID_ADDI, "I");
            chk("stall_ready", {31'b0, idu_ready_o}, 32'd0);
            chk("stall_pc", exu.pc_latched, 32'h108);
        end
        cyc(32'h00500113, 32'h10C, 1, 0, 1, 0, 0, 0, ID_ADDI, "I");
        chk("flush_valid", {31'b0, exu.dec_valid_o}, 32'd0);
        cyc(32'h00500113, 32'h10C, 0, 1, 0, 0, 0, 0, ID_ADDI, "I");
        chk("flush_drop", {31'b0, exu.dec_valid_o}, 32'd0);

        rf[1] = 32'h11;
        cyc(32'h002081B3, 32'h110, 1, 1, 0, 1, 5'd1, 32'h55, ID_ADD, "R");
        chk("bypass_rs1v", exu.rs1_decoded, 32'h55);
        chk("bypass_rs2v", exu.rs2_decoded, rf[2]);

`ifdef PRIRV32_RV32M_EN
        mul_id = ID_MUL;
`else
        mul_id = ID_ILLEGAL;
`endif
        cyc(32'h022081B3, 32'h114, 1, 1, 0, 0, 0, 0, mul_id, "R");
        chk("mul_id", {26'b0, exu.instrset_latched}, {26'b0, mul_id});
        chk("mul_valid", {31'b0, exu.dec_valid_o}, 32'd1);

        cyc(32'h00500113, 32'h118, 0, 0, 0, 0, 0, 0, ID_ADDI, "I");
        @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1 check_reset();
        m_valid = 0;
        @(negedge clk_i) rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            o  = ops[$urandom_range(0, ops.size() - 1)];
            w  = mk(o);
            wa = $urandom_range(0, 1) ? w[19:15] : 5'($urandom_range(0, 31));
            rf[$urandom_range(0, 31)] = $urandom;
            cyc(w, {$urandom, 2'b00} & 32'hFFFF_FFFC,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, wa, $urandom,
                o.id, o.fmt);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
